// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
// Optional feature macro: CORDIC_GAIN_COMP_EN (gain compensation by 1/K).
package cordic_pkg;

    typedef enum logic {
        MODE_ROT = 1'b0,   // rotate (x,y) by z, drive z to 0
        MODE_VEC = 1'b1    // drive y to 0, accumulate atan2 in z
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_GAIN,
        S_OUT
    } state_e;

    // Quadrant constants as 32-bit binary angles; the top keeps the upper WIDTH bits.
    localparam logic [31:0] BAM32_90  = 32'h4000_0000;
    localparam logic [31:0] BAM32_180 = 32'h8000_0000;

    // 1/K in Q1.(width-1), rounded; K = prod sqrt(1 + 2^-2i) over the micro-rotations.
    function automatic int cordic_inv_k(input int width, input int iters);
        real k;
        real p;
        real s;
        k = 1.0;
        p = 1.0;
        for (int i = 0; i < iters; i++) begin
            k = k * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        s = 1.0;
        for (int i = 1; i < width; i++) begin
            s = s * 2.0;
        end
        return $rtoi(s / k + 0.5);
    endfunction

endpackage

// File: rtl/cordic_if.sv
// Start/done operation bus of the CORDIC engine.
interface cordic_if #(
    parameter int WIDTH = 18
);
    logic                    start;
    logic                    mode;
    logic signed [WIDTH-1:0] x0;
    logic signed [WIDTH-1:0] y0;
    logic signed [WIDTH-1:0] z0;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH+1:0] xn;
    logic signed [WIDTH+1:0] yn;
    logic signed [WIDTH-1:0] zn;

    modport master (output start, mode, x0, y0, z0, input busy, done, xn, yn, zn);
    modport slave  (input start, mode, x0, y0, z0, output busy, done, xn, yn, zn);
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: entry i = round(atan(2^-i) / (2*pi) * 2^WIDTH).
// Held as 32-bit binary angles and rounded down to WIDTH bits (WIDTH <= 32).
module cordic_atan_rom #(
    parameter int WIDTH = 18
) (
    input  logic [4:0]       idx,
    output logic [WIDTH-1:0] atan
);
    localparam logic [31:0] ATAN32 [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    // One extra fractional bit lets the same round-half-up expression cover WIDTH = 32.
    assign atan = WIDTH'((34'({ATAN32[idx], 1'b0}) + (34'(1) << (32 - WIDTH))) >> (33 - WIDTH));
endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: rotation and vectoring, one micro-rotation per clock.
// Optional feature macro: CORDIC_GAIN_COMP_EN adds a GAIN state scaling x/y by 1/K.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int ITERS = 16
) (
    input logic     clk,
    input logic     rst,
    cordic_if.slave bus
);
    localparam int XW = WIDTH + 2;
    localparam logic [4:0] LAST = 5'(ITERS - 1);
    localparam logic signed [WIDTH-1:0] ANG_90  = BAM32_90[31 -: WIDTH];
    localparam logic signed [WIDTH-1:0] ANG_180 = BAM32_180[31 -: WIDTH];

    state_e                  state;
    mode_e                   op_mode;
    logic [4:0]              iter;
    logic                    busy;
    logic                    done;
    logic signed [XW-1:0]    xn;
    logic signed [XW-1:0]    yn;
    logic signed [WIDTH-1:0] zn;

    logic signed [XW-1:0]    x;
    logic signed [XW-1:0]    y;
    logic signed [WIDTH-1:0] z;

    logic [WIDTH-1:0]        atan;
    logic                    d_neg;
    logic signed [XW-1:0]    x_sh;
    logic signed [XW-1:0]    y_sh;
    logic signed [XW-1:0]    x_nx;
    logic signed [XW-1:0]    y_nx;
    logic signed [WIDTH-1:0] z_nx;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = XW + WIDTH;
    localparam logic signed [WIDTH-1:0] INV_K = WIDTH'(cordic_inv_k(WIDTH, ITERS));
    localparam logic signed [PW-1:0] G_RND = PW'(1) <<< (WIDTH - 2);

    // Multiply by 1/K (Q1.(WIDTH-1)) with round-half-up back to XW bits.
    function automatic logic signed [XW-1:0] scale(input logic signed [XW-1:0] v);
        return XW'((PW'(v) * PW'(INV_K) + G_RND) >>> (WIDTH - 1));
    endfunction
`endif

    cordic_atan_rom #(.WIDTH(WIDTH)) u_rom (
        .idx  (iter),
        .atan (atan)
    );

    // One micro-rotation; d_neg selects d = -1 (sign of zero counts as +1).
    always_comb begin
        x_sh  = x >>> iter;
        y_sh  = y >>> iter;
        d_neg = (op_mode == MODE_ROT) ? z[WIDTH-1] : ~y[XW-1];
        if (d_neg) begin
            x_nx = x + y_sh;
            y_nx = y - x_sh;
            z_nx = z + $signed(atan);
        end else begin
            x_nx = x - y_sh;
            y_nx = y + x_sh;
            z_nx = z - $signed(atan);
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading pre-edge values, so block order is irrelevant.
        if (rst) begin
            state   <= S_IDLE;
            op_mode <= MODE_ROT;
            iter    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            xn      <= '0;
            yn      <= '0;
            zn      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_mode <= mode_e'(bus.mode);
                        busy    <= 1'b1;
                        state   <= S_PRE;
                    end
                end
                S_PRE: begin
                    iter  <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    if (iter == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state <= S_GAIN;
`else
                        state <= S_OUT;
`endif
                    end else begin
                        iter <= iter + 5'd1;
                    end
                end
                S_GAIN: state <= S_OUT;
                S_OUT: begin
                    xn    <= x;
                    yn    <= y;
                    zn    <= z;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Working x/y/z registers: load, quadrant pre-rotation, iterate, optional gain.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these registers are always reloaded at start before anything reads them.
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    x <= {{2{bus.x0[WIDTH-1]}}, bus.x0};
                    y <= {{2{bus.y0[WIDTH-1]}}, bus.y0};
                    z <= bus.mode ? '0 : bus.z0;
                end
            end
            S_PRE: begin
                if (op_mode == MODE_ROT) begin
                    if (z >= ANG_90 || z < -ANG_90) begin
                        x <= -x;
                        y <= -y;
                        z <= z + ANG_180;
                    end
                end else if (x[XW-1]) begin
                    x <= -x;
                    y <= -y;
                    z <= ANG_180;
                end
            end
            S_ITER: begin
                x <= x_nx;
                y <= y_nx;
                z <= z_nx;
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_GAIN: begin
                x <= scale(x);
                y <= scale(y);
            end
`endif
            default: ;
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.xn   = xn;
    assign bus.yn   = yn;
    assign bus.zn   = zn;
endmodule
